beta_bus_ctrl: RTL
==================

Name: beta_bus_ctrl

Overview:
Parametrised successor to the Beta memory-bus address decoder. Decodes a configurable page field of the CPU address into N one-hot slave selects and runs a registered request/acknowledge handshake with per-slave wait states. Stalls the Beta until the slave acknowledges, then returns the muxed read data. Unmapped pages and slave timeouts raise a sticky error IRQ with the captured address; there is no silent fallback to RAM. Sits between the Beta core and the RAM, memory-mapped IO and shared-block slaves.

Parameters:
NUM_SLAVES, 4, number of slaves; page p selects slave p for p < NUM_SLAVES
SEL_HI, 31, MSB of the page field in mem_addr
SEL_LO, 16, LSB of the page field in mem_addr
TIMEOUT, 255, maximum WAIT cycles before a timeout error (1..255)
ERR_DATA, 32'h0000_0000, read data returned on any error

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
mem_addr  in  32  Beta address
mem_re  in  1  Beta read request
mem_we  in  1  Beta write request
cpu_stall  out  1  hold the Beta pipeline
cpu_rdata  out  32  read data to the Beta
slave_sel  out  NUM_SLAVES  one-hot slave select, registered
slave_re  out  1  registered read strobe to the selected slave
slave_we  out  1  registered write strobe to the selected slave
slave_ack  in  NUM_SLAVES  per-slave completion
slave_rdata  in  32*NUM_SLAVES  packed slave read data; slave i occupies bits [32i+31:32i]
err_irq  out  1  sticky error interrupt
err_addr  out  32  address of the first uncleared error
err_timeout  out  1  error cause: 1 = timeout, 0 = unmapped page
err_clr  in  1  clears err_irq

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE. slave_sel=0, slave_re=0, slave_we=0, cpu_rdata=0, err_irq=0, err_addr=0, err_timeout=0, timeout counter=0. Reset mid-transaction aborts the transaction immediately.
- Request signal: req = mem_re | mem_we. If both are high, it is treated as a write.
- cpu_stall = req & (state != DONE). It is combinational and is the only combinational output.
- IDLE, req high, page = mem_addr[SEL_HI:SEL_LO]:
  - page < NUM_SLAVES: latch the index, set slave_sel one-hot and slave_re/slave_we, clear the counter, go to WAIT.
  - otherwise: go to ERR.
- WAIT:
  - slave_ack[idx] high: register the selected slave's rdata into cpu_rdata (writes register it too; the value is ignored), drop sel and strobes, go to DONE.
  - counter == TIMEOUT-1 without ack: go to ERR with timeout cause.
  - otherwise: counter increments.
  - req drops (Beta flushed): drop sel and strobes, return to IDLE, no error.
  - ack from a non-selected slave is ignored.
- ERR (one cycle): cpu_rdata=ERR_DATA, drop sel and strobes, set err_irq. Capture err_addr and err_timeout only if err_irq was 0 (first error wins). Go to DONE.
- DONE (one cycle): stall is released and the Beta consumes cpu_rdata. Return to IDLE; a new request is decoded on the following cycle.
- Latency: ack in the first WAIT cycle gives 3 cycles from request to stall release. Unmapped page gives 3 cycles.
- err_clr: clears err_irq on the next edge. If err_clr and a new error occur in the same cycle, the error wins (err_irq stays 1, new address captured).
- mem_addr is not re-sampled after IDLE. The Beta holds it while stalled.

Decomposition:
- Package beta_bus_pkg: state encoding (IDLE, WAIT, DONE, ERR), page-field width constant, ERR_DATA default, slave index constants (RAM=0, IO=1, RD_SHARED=2, WR_SHARED=3).
- Sub-module beta_page_decode: combinational page compare producing a one-hot select, a binary index and a valid flag, parametrised on NUM_SLAVES, SEL_HI and SEL_LO.

Test Plan:
1. Read 0x0000_0040, slave 0 acks in the 1st WAIT cycle with 0x1234_5678 -> sel=0001 for 1 cycle, stall high 2 cycles, cpu_rdata=0x1234_5678 in DONE, err_irq=0.
2. Write 0x0001_0004, slave 1 acks after 5 WAIT cycles -> slave_we and sel=0010 held 5 cycles, stall released on the 7th cycle.
3. Read 0x0007_0000 -> no sel, err_irq=1, err_addr=0x0007_0000, err_timeout=0, cpu_rdata=0.
4. TIMEOUT=8, read page 2, no ack -> ERR after 8 WAIT cycles, err_timeout=1. A second error before err_clr leaves err_addr unchanged.
5. err_clr asserted in the same cycle as a new unmapped access -> err_irq stays 1, err_addr updated to the new address.
6. Assert reset_n=0 mid-WAIT, then mem_re dropped mid-WAIT -> sel and strobes are 0 the next cycle, state IDLE, no error raised.

Source files
------------

// File: rtl/beta_bus_pkg.sv
// Shared definitions for the Beta memory-bus controller.
// Provides the FSM state encoding, the default page-field width,
// the error read-data default and the conventional slave map indices.
package beta_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } bus_state_t;

  // Default width of the page field taken from the top of mem_addr.
  localparam int PAGE_W = 16;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

  // Conventional slave map of the Beta system.
  localparam int SLV_RAM       = 0;
  localparam int SLV_IO        = 1;
  localparam int SLV_RD_SHARED = 2;
  localparam int SLV_WR_SHARED = 3;

endpackage

// File: rtl/beta_page_decode.sv
// Page decoder: maps the page field onto a one-hot select, a binary index and a valid flag.
// Latency: purely combinational. Backpressure: none.
// Ports: page (page field of the address) -> sel_onehot, idx, valid (page < NUM_SLAVES).
module beta_page_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_HI     = 31,
  parameter int SEL_LO     = 16,
  parameter int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [SEL_HI-SEL_LO:0] page,
  output logic [NUM_SLAVES-1:0]  sel_onehot,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  localparam int PW = SEL_HI - SEL_LO + 1;

  logic [31:0] page_ext;

  always_comb begin
    page_ext           = '0;
    page_ext[PW-1:0]   = page;
    valid              = (page_ext < 32'(NUM_SLAVES));
    idx                = page_ext[IDX_W-1:0];
    sel_onehot         = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_onehot[i] = valid && (page_ext == 32'(i));
    end
  end

endmodule

// File: rtl/beta_bus_ctrl.sv
// Beta bus controller: decodes the address page to a slave, runs a registered req/ack
// handshake with timeout, and returns muxed read data. Request-to-release latency is
// 3 cycles minimum; the Beta is stalled (cpu_stall) until the slave acks or an error ends it.
// Ports: mem_* from the Beta, cpu_stall/cpu_rdata back to it, slave_* to/from the slaves,
// err_irq/err_addr/err_timeout sticky error report cleared by err_clr.
module beta_bus_ctrl
  import beta_bus_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter int          SEL_HI     = 31,
  parameter int          SEL_LO     = SEL_HI - PAGE_W + 1,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              mem_addr,
  input  logic                     mem_re,
  input  logic                     mem_we,
  output logic                     cpu_stall,
  output logic [31:0]              cpu_rdata,
  output logic [NUM_SLAVES-1:0]    slave_sel,
  output logic                     slave_re,
  output logic                     slave_we,
  input  logic [NUM_SLAVES-1:0]    slave_ack,
  input  logic [32*NUM_SLAVES-1:0] slave_rdata,
  output logic                     err_irq,
  output logic [31:0]              err_addr,
  output logic                     err_timeout,
  input  logic                     err_clr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  bus_state_t            state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic                  re_q, re_d, we_q, we_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic [31:0]           eaddr_q, eaddr_d;
  logic                  etmo_q, etmo_d;
  logic                  cause_q, cause_d;   // cause of the error being processed in ST_ERR
  logic [7:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic                  req;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_valid;

  beta_page_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_HI     (SEL_HI),
    .SEL_LO     (SEL_LO),
    .IDX_W      (IDX_W)
  ) u_decode (
    .page       (mem_addr[SEL_HI:SEL_LO]),
    .sel_onehot (dec_sel),
    .idx        (dec_idx),
    .valid      (dec_valid)
  );

  assign req = mem_re | mem_we;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    re_d    = re_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    irq_d   = irq_q & ~err_clr;
    eaddr_d = eaddr_q;
    etmo_d  = etmo_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (dec_valid) begin
            idx_d   = dec_idx;
            sel_d   = dec_sel;
            we_d    = mem_we;
            re_d    = mem_re & ~mem_we;   // simultaneous re/we is a write
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            cause_d = 1'b0;
            state_d = ST_ERR;
          end
        end
      end
      ST_WAIT: begin
        // A flush takes priority: the Beta no longer wants the result.
        if (!req) begin
          sel_d   = '0;
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (slave_ack[idx_q]) begin
          rdata_d = slave_rdata[32*int'(idx_q) +: 32];
          sel_d   = '0;
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          sel_d   = '0;
          re_d    = 1'b0;
          we_d    = 1'b0;
          cause_d = 1'b1;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ERR: begin
        rdata_d = ERR_DATA;
        irq_d   = 1'b1;
        // First error wins, unless the old one is being cleared this very cycle.
        if (!irq_q || err_clr) begin
          eaddr_d = mem_addr;
          etmo_d  = cause_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      eaddr_q <= '0;
      etmo_q  <= 1'b0;
      cause_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      re_q    <= re_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      eaddr_q <= eaddr_d;
      etmo_q  <= etmo_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign cpu_stall   = req & (state_q != ST_DONE);
  assign cpu_rdata   = rdata_q;
  assign slave_sel   = sel_q;
  assign slave_re    = re_q;
  assign slave_we    = we_q;
  assign err_irq     = irq_q;
  assign err_addr    = eaddr_q;
  assign err_timeout = etmo_q;

endmodule
